// File: rtl/score_display_pkg.sv
// ---------------------------------------------------------------------------
// score_display_pkg
// Shared types and constants for the score display driver:
//   state_t       - conversion FSM states
//   SEG_*         - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   DIGIT_CODE_W  - width of a stored digit code (hex nibble plus dash code)
//   CODE_DASH     - digit code shown for an overflowed half
//   seg_decode()  - digit code to segment pattern
// ---------------------------------------------------------------------------
package score_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } state_t;

    localparam int DIGIT_CODE_W = 5;

    localparam logic [DIGIT_CODE_W-1:0] CODE_DASH = 5'd16;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Codes 0..15 are hex digits, 16 is the dash; anything else blanks.
    function automatic logic [6:0] seg_decode(input logic [DIGIT_CODE_W-1:0] code);
        logic [6:0] pat;
        case (code)
            5'd0:    pat = SEG_0;
            5'd1:    pat = SEG_1;
            5'd2:    pat = SEG_2;
            5'd3:    pat = SEG_3;
            5'd4:    pat = SEG_4;
            5'd5:    pat = SEG_5;
            5'd6:    pat = SEG_6;
            5'd7:    pat = SEG_7;
            5'd8:    pat = SEG_8;
            5'd9:    pat = SEG_9;
            5'd10:   pat = SEG_A;
            5'd11:   pat = SEG_B;
            5'd12:   pat = SEG_C;
            5'd13:   pat = SEG_D;
            5'd14:   pat = SEG_E;
            5'd15:   pat = SEG_F;
            5'd16:   pat = SEG_DASH;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/score_display_driver_if.sv
// ---------------------------------------------------------------------------
// score_display_driver_if
// Bundle between the scoreboard display stage and the display driver.
//   display_data [31:0] : [31:16] user id, [15:0] score (scoreboard -> driver)
//   seg          [6:0]  : active-low segments {g,f,e,d,c,b,a} (driver -> pins)
//   an           [7:0]  : active-low digit enables, an[7] leftmost
//   busy                : conversion in progress
// master = scoreboard/board side, slave = the driver.
// ---------------------------------------------------------------------------
interface score_display_driver_if;
    logic [31:0] display_data;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        busy;

    modport master (output display_data, input seg, input an, input busy);
    modport slave  (input display_data, output seg, output an, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// 16-bit sequential double-dabble converter. The parent owns sequencing:
// pulse load once, then hold shift_en for exactly 16 cycles; bcd is then the
// five-digit decimal value of bin.
//   clk, rst   : clock, synchronous active-low reset
//   load       : capture bin and clear the BCD accumulator
//   shift_en   : perform one add-3 / shift-left step
//   bin [15:0] : binary value to convert (sampled on load)
//   bcd [19:0] : five BCD digits, ten-thousands in [19:16]
// ---------------------------------------------------------------------------
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift_en,
    input  logic [15:0] bin,
    output logic [19:0] bcd
);

    logic [15:0] bin_sr;
    logic [19:0] bcd_r;
    logic [18:0] bcd_adj;

    // The top digit never reaches 5 before a shift (pre-shift value is at
    // most 32767), so only the lower four nibbles need the add-3 correction
    // and bit 19 is never shifted out.
    always_comb begin
        bcd_adj = bcd_r[18:0];
        for (int i = 0; i < 4; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_sr <= '0;
            bcd_r  <= '0;
        end else if (load) begin
            bin_sr <= bin;
            bcd_r  <= '0;
        end else if (shift_en) begin
            bcd_r  <= {bcd_adj, bin_sr[15]};
            bin_sr <= {bin_sr[14:0], 1'b0};
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/score_display_driver.sv
// ---------------------------------------------------------------------------
// score_display_driver
// Watches the scoreboard display word, converts user id and score to four
// digits each (decimal with overflow dashes, or raw hex), commits them to
// tear-free digit registers and scans them onto a common-anode 8-digit
// 7-segment bank.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : score_display_driver_if.slave (display_data in; seg, an, busy out)
// Parameters:
//   SCAN_DIV : clk cycles each digit stays lit (>= 2)
//   BCD_MODE : 1 = decimal with dashes for values >= 10000, 0 = hex nibbles
// ---------------------------------------------------------------------------
module score_display_driver
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BCD_MODE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    score_display_driver_if.slave  bus
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic                     busy_c;
    logic                     conv_load;
    logic                     conv_shift;
    logic                     commit;

    logic [31:0]              shadow;
    logic [3:0]               shift_cnt;
    logic [19:0]              bcd_u;
    logic [19:0]              bcd_s;
    logic [DIGIT_CODE_W-1:0]  digit     [8];
    logic [DIGIT_CODE_W-1:0]  digit_nxt [8];

    logic [DIV_W-1:0]         div;
    logic [2:0]               scan_idx;
    logic [7:0]               an_p1;
    logic [6:0]               seg_p1;

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.display_data != shadow) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SHIFT;
            S_SHIFT:  if (shift_cnt == 4'd15) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy_c     = 1'b0;
        conv_load  = 1'b0;
        conv_shift = 1'b0;
        commit     = 1'b0;
        case (state)
            S_LOAD: begin
                busy_c    = 1'b1;
                conv_load = 1'b1;
            end
            S_SHIFT: begin
                busy_c     = 1'b1;
                conv_shift = 1'b1;
            end
            S_COMMIT: begin
                busy_c = 1'b1;
                commit = 1'b1;
            end
            default: ;
        endcase
    end

    // Converters take display_data directly on the same edge the shadow
    // captures it, so shadow and converter inputs always agree.
    bin2bcd_seq u_conv_user (
        .clk      (clk),
        .rst      (rst),
        .load     (conv_load),
        .shift_en (conv_shift),
        .bin      (bus.display_data[31:16]),
        .bcd      (bcd_u)
    );

    bin2bcd_seq u_conv_score (
        .clk      (clk),
        .rst      (rst),
        .load     (conv_load),
        .shift_en (conv_shift),
        .bin      (bus.display_data[15:0]),
        .bcd      (bcd_s)
    );

    // Digit codes to commit: index 7..4 user id, 3..0 score, MSD first.
    always_comb begin
        for (int k = 0; k < 8; k++) digit_nxt[k] = '0;
        for (int k = 0; k < 4; k++) begin
            if (BCD_MODE) begin
                digit_nxt[k+4] = (bcd_u[19:16] != 4'd0) ? CODE_DASH
                                                        : {1'b0, bcd_u[4*k +: 4]};
                digit_nxt[k]   = (bcd_s[19:16] != 4'd0) ? CODE_DASH
                                                        : {1'b0, bcd_s[4*k +: 4]};
            end else begin
                digit_nxt[k+4] = {1'b0, shadow[16 + 4*k +: 4]};
                digit_nxt[k]   = {1'b0, shadow[4*k +: 4]};
            end
        end
    end

    // Digit registers only change on the commit edge, so the scan never
    // shows a half-converted value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow    <= '0;
            shift_cnt <= '0;
            for (int k = 0; k < 8; k++) digit[k] <= '0;
        end else begin
            if (conv_load) begin
                shadow    <= bus.display_data;
                shift_cnt <= '0;
            end else if (conv_shift) begin
                shift_cnt <= shift_cnt + 4'd1;
            end
            if (commit) begin
                for (int k = 0; k < 8; k++) digit[k] <= digit_nxt[k];
            end
        end
    end

    // ---- scan stage p0: divider and index ----
    // ---- scan stage p1: registered anode and segment pins ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            div      <= '0;
            scan_idx <= '0;
            an_p1    <= 8'hFF;
            seg_p1   <= SEG_BLANK;
        end else begin
            if (div == DIV_LAST) begin
                div      <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
            an_p1  <= ~(8'd1 << scan_idx);
            seg_p1 <= seg_decode(digit[scan_idx]);
        end
    end

    assign bus.an   = an_p1;
    assign bus.seg  = seg_p1;
    assign bus.busy = busy_c;

endmodule

// File: tb/tb_score_display_driver.sv
// ---------------------------------------------------------------------------
// tb_score_display_driver
// Directed bench: a decimal-mode driver (bus0) and a hex-mode driver (bus1),
// both with SCAN_DIV=4, sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_score_display_driver;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    score_display_driver_if bus0 ();
    score_display_driver_if bus1 ();

    score_display_driver #(.SCAN_DIV(4), .BCD_MODE(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    score_display_driver #(.SCAN_DIV(4), .BCD_MODE(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [6:0] cap [7:0];

    function automatic logic get_busy(input bit sel);
        return sel ? bus1.busy : bus0.busy;
    endfunction

    // Record the segment pattern shown while each anode is active.
    task automatic capture(input bit sel);
        logic [7:0] an_v;
        for (int k = 0; k < 8; k++) cap[k] = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            an_v = sel ? bus1.an : bus0.an;
            for (int k = 0; k < 8; k++) begin
                if (an_v == ~(8'd1 << k)) cap[k] = sel ? bus1.seg : bus0.seg;
            end
        end
    endtask

    // Wait (bounded) for busy to rise, then count negedges it stays high.
    task automatic run_conv(input bit sel, output int len);
        int t;
        len = 0;
        t   = 0;
        @(negedge clk);
        while (!get_busy(sel) && t < 10) begin
            @(negedge clk);
            t++;
        end
        while (get_busy(sel) && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int len;
        rst = 1'b0;
        bus0.display_data = 32'h1234_5678;
        bus1.display_data = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (bus0.an !== 8'hFF) begin
            err_cnt++;
            $display("FAIL reset_an: got %h expected ff", bus0.an);
        end
        vec_cnt++;
        if (bus0.seg !== 7'h7F) begin
            err_cnt++;
            $display("FAIL reset_seg: got %h expected 7f", bus0.seg);
        end
        vec_cnt++;
        if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_busy: got %b/%b expected 0/0", bus0.busy, bus1.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus0.busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_release_busy: got %b expected 1", bus0.busy);
        end
        len = 0;
        while (bus0.busy && len < 40) begin
            len++;
            @(negedge clk);
        end
        vec_cnt++;
        if (len != 18) begin
            err_cnt++;
            $display("FAIL reset_first_conv_len: got %0d expected 18", len);
        end
    endtask

    task automatic test_bcd_basic();
        int len;
        logic [6:0] exp [7:0];
        exp = '{7'h40, 7'h40, 7'h19, 7'h24, 7'h10, 7'h10, 7'h10, 7'h10};
        bus0.display_data = {16'd42, 16'd9999};
        run_conv(1'b0, len);
        vec_cnt++;
        if (len != 18) begin
            err_cnt++;
            $display("FAIL bcd_busy_len: got %0d expected 18", len);
        end
        capture(1'b0);
        for (int k = 7; k >= 0; k--) begin
            vec_cnt++;
            if (cap[k] !== exp[k]) begin
                err_cnt++;
                $display("FAIL bcd_digit%0d: got %h expected %h", k, cap[k], exp[k]);
            end
        end
    endtask

    task automatic test_overflow();
        int len;
        logic [6:0] exp [7:0];
        exp = '{7'h40, 7'h40, 7'h40, 7'h78, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        bus0.display_data = {16'd7, 16'd10000};
        run_conv(1'b0, len);
        vec_cnt++;
        if (len != 18) begin
            err_cnt++;
            $display("FAIL ovf_busy_len: got %0d expected 18", len);
        end
        capture(1'b0);
        for (int k = 7; k >= 0; k--) begin
            vec_cnt++;
            if (cap[k] !== exp[k]) begin
                err_cnt++;
                $display("FAIL ovf_digit%0d: got %h expected %h", k, cap[k], exp[k]);
            end
        end
    endtask

    task automatic test_mid_change();
        int len;
        int t;
        bus0.display_data = 32'd5;
        t = 0;
        @(negedge clk);
        while (!bus0.busy && t < 10) begin
            @(negedge clk);
            t++;
        end
        // First negedge with busy high is the LOAD cycle; the 9th is SHIFT cycle 8.
        len = 0;
        while (bus0.busy && len < 40) begin
            len++;
            if (len == 9) bus0.display_data = 32'd6;
            @(negedge clk);
        end
        vec_cnt++;
        if (len != 18) begin
            err_cnt++;
            $display("FAIL mid_first_len: got %0d expected 18", len);
        end
        vec_cnt++;
        if (bus0.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_gap: busy got %b expected 0", bus0.busy);
        end
        @(negedge clk);
        vec_cnt++;
        if (bus0.busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_retrigger: busy got %b expected 1", bus0.busy);
        end
        len = 0;
        while (bus0.busy && len < 40) begin
            len++;
            @(negedge clk);
        end
        vec_cnt++;
        if (len != 18) begin
            err_cnt++;
            $display("FAIL mid_second_len: got %0d expected 18", len);
        end
        capture(1'b0);
        vec_cnt++;
        if (cap[0] !== 7'h02) begin
            err_cnt++;
            $display("FAIL mid_digit0: got %h expected 02", cap[0]);
        end
        vec_cnt++;
        if (cap[1] !== 7'h40 || cap[4] !== 7'h40) begin
            err_cnt++;
            $display("FAIL mid_digit1_4: got %h/%h expected 40/40", cap[1], cap[4]);
        end
    endtask

    task automatic test_scan_wrap();
        logic [7:0] prev;
        bit         found;
        found = 1'b0;
        prev  = bus0.an;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            if (prev == 8'h7F && bus0.an == 8'hFE) found = 1'b1;
            else prev = bus0.an;
        end
        vec_cnt++;
        if (!found) begin
            err_cnt++;
            $display("FAIL scan_sync: no 7f->fe wrap seen, an=%h", bus0.an);
        end else begin
            for (int i = 0; i < 32; i++) begin
                vec_cnt++;
                if (bus0.an !== ~(8'd1 << (i / 4))) begin
                    err_cnt++;
                    $display("FAIL scan_an_cycle%0d: got %h expected %h",
                             i, bus0.an, ~(8'd1 << (i / 4)));
                end
                @(negedge clk);
            end
            vec_cnt++;
            if (bus0.an !== 8'hFE) begin
                err_cnt++;
                $display("FAIL scan_wrap: got %h expected fe", bus0.an);
            end
        end
    endtask

    task automatic test_hex_mode();
        int len;
        logic [6:0] exp [7:0];
        exp = '{7'h03, 7'h06, 7'h06, 7'h0E, 7'h40, 7'h08, 7'h79, 7'h46};
        bus1.display_data = 32'hBEEF_0A1C;
        run_conv(1'b1, len);
        vec_cnt++;
        if (len != 18) begin
            err_cnt++;
            $display("FAIL hex_busy_len: got %0d expected 18", len);
        end
        capture(1'b1);
        for (int k = 7; k >= 0; k--) begin
            vec_cnt++;
            if (cap[k] !== exp[k]) begin
                err_cnt++;
                $display("FAIL hex_digit%0d: got %h expected %h", k, cap[k], exp[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus0.display_data = '0;
        bus1.display_data = '0;
        test_reset();
        test_bcd_basic();
        test_overflow();
        test_mid_change();
        test_scan_wrap();
        test_hex_mode();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
